mem_arbiter_rr2: RTL
====================

Name: mem_arbiter_rr2

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port valid/ready memory (WIDTH x DEPTH, registered ready/read data).
- Accepts one transaction at a time from requester A or B, issues a single-cycle valid pulse to the memory, waits for the memory's ready, and returns completion and read data to the winning requester.

Parameters:
- WIDTH, 16, data width; must match the memory.
- DEPTH, 1024, memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- CNT_WIDTH, 16, width of grant counters (optional feature only).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- a_valid_i  in  1  requester A has a transaction; held until a_ack_o.
- a_wr_rd_i  in  1  1 = write, 0 = read.
- a_addr_i  in  ADDR_WIDTH  A address.
- a_wr_data_i  in  WIDTH  A write data.
- a_ack_o  out  1  one-cycle pulse: A's request latched.
- a_rsp_valid_o  out  1  one-cycle pulse: A's transaction complete.
- b_valid_i, b_wr_rd_i, b_addr_i, b_wr_data_i, b_ack_o, b_rsp_valid_o: same as A for requester B.
- rsp_rd_data_o  out  WIDTH  read data; valid with a_/b_rsp_valid_o on reads.
- mem_valid_o  out  1  to memory valid_i.
- mem_wr_rd_o  out  1  to memory wr_rd_i.
- mem_addr_o  out  ADDR_WIDTH  to memory addr_i.
- mem_wr_data_o  out  WIDTH  to memory wr_data_i.
- mem_rd_data_i  in  WIDTH  from memory rd_data_o.
- mem_ready_i  in  1  from memory ready_o.
- a_gnt_cnt_o, b_gnt_cnt_o  out  CNT_WIDTH  grant counters (see Optional Feature).

Behaviour:
- Reset: state IDLE; all outputs 0; last_gnt = B, so A wins the first tie. Reset mid-transaction aborts it with no ack or rsp pulse; the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any valid, pick a winner, latch its wr_rd/addr/wr_data into mem_*_o, set mem_valid_o, pulse the winner's ack for the next cycle, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_valid_o = 1 for exactly this cycle; ack high this cycle; go to WAIT.
  - WAIT: mem_valid_o = 0. When mem_ready_i = 1, capture mem_rd_data_i into rsp_rd_data_o (reads only) and go to RESP. Otherwise stay in WAIT indefinitely.
  - RESP: winner's rsp_valid_o = 1 for this cycle only; go to IDLE.
- Arbitration: only one requester valid -> it wins. Both valid -> the one not equal to last_gnt wins. last_gnt updates on the IDLE->ISSUE transition.
- Latency: valid seen in IDLE at cycle 0 -> ack at cycle 1 -> rsp_valid at cycle 3. Throughput is 1 transaction per 4 cycles.
- Writes: rsp_valid pulses; rsp_rd_data_o holds its previous value.
- Requests arriving outside IDLE wait; a loser is never acked until it wins.
- mem_addr_o, mem_wr_rd_o and mem_wr_data_o hold stable from ISSUE through RESP.
- A valid dropped before ack is legal: no transaction results.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined: a_gnt_cnt_o and b_gnt_cnt_o increment on each grant to A or B respectively. They saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are built; the interface is unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - requester IDs REQ_A=1'b0, REQ_B=1'b1.
- One sub-module, rr_arb2: combinational 2-way round-robin pick (inputs req_a, req_b, last_gnt; outputs gnt_valid, gnt_id). The FSM, datapath registers and counters live in the top module.

Test Plan:
- Reset then A write only (addr 0x005, data 0xBEEF) -> a_ack_o at cycle 1, mem_valid_o high for 1 cycle, a_rsp_valid_o at cycle 3; b_* outputs stay 0.
- B read of addr 0x005 after the above -> b_rsp_valid_o with rsp_rd_data_o = 0xBEEF, 3 cycles after acceptance.
- A and B both valid continuously, 6 transactions -> grants alternate A, B, A, B, A, B, one every 4 cycles.
- A write 0x1234 @0x3FF, then A read @0x3FF -> read returns 0x1234 (top address, no wrap).
- rst asserted in WAIT -> next cycle all outputs 0, no rsp pulse; after release, A's held request is re-granted first.
- With MEM_ARB_PERF_CNT_EN and the 6-grant test -> a_gnt_cnt_o = 3, b_gnt_cnt_o = 3. Without the macro -> both counters read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   state_t      : sequencer states (IDLE, ISSUE, WAIT, RESP)
//   REQ_A, REQ_B : requester identifiers used for grant/last-grant tracking
package mem_arb_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req_a, req_b : pending requests from A and B
//   last_gnt     : requester granted most recently
//   gnt_valid    : at least one request present
//   gnt_id       : winning requester (REQ_A / REQ_B)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = REQ_A;
    if (req_a && req_b) begin
      gnt_id = (last_gnt == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      gnt_id = REQ_B;
    end
  end

endmodule

// File: rtl/mem_arbiter_rr2.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port
// valid/ready memory. One transaction in flight; 4-cycle throughput.
// Optional grant counters are built when MEM_ARB_PERF_CNT_EN is defined,
// otherwise a_gnt_cnt_o / b_gnt_cnt_o are tied to 0.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   a_* / b_* (valid, wr_rd, addr, wr_data in; ack, rsp_valid out)
//   rsp_rd_data_o                    : read data, valid with *_rsp_valid_o
//   mem_valid_o/wr_rd_o/addr_o/wr_data_o, mem_rd_data_i, mem_ready_i
//   a_gnt_cnt_o, b_gnt_cnt_o         : saturating grant counters
module mem_arbiter_rr2
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid_i,
  input  logic                  a_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [WIDTH-1:0]      a_wr_data_i,
  output logic                  a_ack_o,
  output logic                  a_rsp_valid_o,
  input  logic                  b_valid_i,
  input  logic                  b_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [WIDTH-1:0]      b_wr_data_i,
  output logic                  b_ack_o,
  output logic                  b_rsp_valid_o,
  output logic [WIDTH-1:0]      rsp_rd_data_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wr_data_o,
  input  logic [WIDTH-1:0]      mem_rd_data_i,
  input  logic                  mem_ready_i,
  output logic [CNT_WIDTH-1:0]  a_gnt_cnt_o,
  output logic [CNT_WIDTH-1:0]  b_gnt_cnt_o
);

  state_t                state_q, state_nxt;
  logic                  last_gnt_q, last_gnt_nxt;
  logic                  a_ack_nxt, b_ack_nxt;
  logic                  a_rsp_nxt, b_rsp_nxt;
  logic                  mem_valid_nxt, mem_wr_rd_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [WIDTH-1:0]      mem_wr_data_nxt, rsp_rd_data_nxt;
  logic                  gnt_valid, gnt_id;

  rr_arb2 u_rr_arb2 (
    .req_a     (a_valid_i),
    .req_b     (b_valid_i),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_gnt_q    <= REQ_B;
      a_ack_o       <= 1'b0;
      b_ack_o       <= 1'b0;
      a_rsp_valid_o <= 1'b0;
      b_rsp_valid_o <= 1'b0;
      mem_valid_o   <= 1'b0;
      mem_wr_rd_o   <= 1'b0;
      mem_addr_o    <= '0;
      mem_wr_data_o <= '0;
      rsp_rd_data_o <= '0;
    end else begin
      state_q       <= state_nxt;
      last_gnt_q    <= last_gnt_nxt;
      a_ack_o       <= a_ack_nxt;
      b_ack_o       <= b_ack_nxt;
      a_rsp_valid_o <= a_rsp_nxt;
      b_rsp_valid_o <= b_rsp_nxt;
      mem_valid_o   <= mem_valid_nxt;
      mem_wr_rd_o   <= mem_wr_rd_nxt;
      mem_addr_o    <= mem_addr_nxt;
      mem_wr_data_o <= mem_wr_data_nxt;
      rsp_rd_data_o <= rsp_rd_data_nxt;
    end
  end

  // Next state and next output values; pulses default low, payload holds.
  always_comb begin
    state_nxt       = state_q;
    last_gnt_nxt    = last_gnt_q;
    a_ack_nxt       = 1'b0;
    b_ack_nxt       = 1'b0;
    a_rsp_nxt       = 1'b0;
    b_rsp_nxt       = 1'b0;
    mem_valid_nxt   = 1'b0;
    mem_wr_rd_nxt   = mem_wr_rd_o;
    mem_addr_nxt    = mem_addr_o;
    mem_wr_data_nxt = mem_wr_data_o;
    rsp_rd_data_nxt = rsp_rd_data_o;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_nxt     = ST_ISSUE;
          last_gnt_nxt  = gnt_id;
          mem_valid_nxt = 1'b1;
          if (gnt_id == REQ_A) begin
            a_ack_nxt       = 1'b1;
            mem_wr_rd_nxt   = a_wr_rd_i;
            mem_addr_nxt    = a_addr_i;
            mem_wr_data_nxt = a_wr_data_i;
          end else begin
            b_ack_nxt       = 1'b1;
            mem_wr_rd_nxt   = b_wr_rd_i;
            mem_addr_nxt    = b_addr_i;
            mem_wr_data_nxt = b_wr_data_i;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_ready_i) begin
          state_nxt = ST_RESP;
          // Writes leave the last read data untouched.
          if (!mem_wr_rd_o) rsp_rd_data_nxt = mem_rd_data_i;
          a_rsp_nxt = (last_gnt_q == REQ_A);
          b_rsp_nxt = (last_gnt_q == REQ_B);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic grant_c;
  assign grant_c = (state_q == ST_IDLE) && gnt_valid;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_gnt_cnt_o <= '0;
      b_gnt_cnt_o <= '0;
    end else if (grant_c) begin
      if (gnt_id == REQ_A && a_gnt_cnt_o != '1) a_gnt_cnt_o <= a_gnt_cnt_o + CNT_WIDTH'(1);
      if (gnt_id == REQ_B && b_gnt_cnt_o != '1) b_gnt_cnt_o <= b_gnt_cnt_o + CNT_WIDTH'(1);
    end
  end
`else
  assign a_gnt_cnt_o = '0;
  assign b_gnt_cnt_o = '0;
`endif

endmodule
